simmem_resp_slot_bank: RTL and testbench

Response storage bank on the release side of the simulated memory controller.
- Reserves a slot per incoming request and returns its local identifier, which is forwarded with the delay to the delay bank.
- Stores the real memory's response in the oldest reserved slot of the matching AXI ID.
- Emits the response downstream only when the delay bank asserts that slot's release_en bit. On the output handshake it reports the one-hot released slot back to the delay bank.

---
 rtl/simmem_pkg.sv | 28 ++
 rtl/simmem_age_matrix.sv | 65 ++++++
 rtl/simmem_resp_slot_bank.sv | 154 +++++++++++++++
 tb/tb_simmem_resp_slot_bank.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : simmem_pkg
// Brief  : Shared types and default sizing for the simulated memory
//          controller response slot bank.
// Rev    : 1.0 - initial release
// ============================================================================
package simmem_pkg;

  localparam int unsigned DefaultCapacity  = 64;
  localparam int unsigned DefaultIdWidth   = 4;
  localparam int unsigned DefaultDataWidth = 16;

  // Lifecycle of one response slot.
  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FILLED   = 2'd2
  } slot_state_e;

  // One stored response at the default widths.
  typedef struct packed {
    logic [DefaultIdWidth-1:0]   id;
    logic [DefaultDataWidth-1:0] data;
  } resp_t;

endpackage
`default_nettype wire

// File: rtl/simmem_age_matrix.sv
`default_nettype none
// ============================================================================
// Module : simmem_age_matrix
// Brief  : Relative age tracker for the slots of the response bank.
//          older_q[i][j] = 1 means slot i was reserved before slot j.
//          A newly set slot becomes younger than every live slot; a cleared
//          slot drops out of every relation.
// Rev    : 1.0 - initial release
// ============================================================================
module simmem_age_matrix #(
  parameter int unsigned Capacity = 4
) (
  input  logic                               clk,
  input  logic                               rst_ni,
  input  logic [Capacity-1:0]                set_onehot_i,
  input  logic [Capacity-1:0]                clear_onehot_i,
  input  logic [Capacity-1:0]                live_i,
  input  logic [Capacity-1:0]                mask_i,
  output logic [Capacity-1:0]                oldest_onehot_o,
  output logic [Capacity-1:0][Capacity-1:0]  older_than_o
);

  logic [Capacity-1:0][Capacity-1:0] older_q, older_d;

  // Next matrix: clearing wins, then the new slot's column/row is written.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        if (clear_onehot_i[i] || clear_onehot_i[j] || (i == j)) begin
          older_d[i][j] = 1'b0;
        end else if (set_onehot_i[j]) begin
          older_d[i][j] = live_i[i];
        end else if (set_onehot_i[i]) begin
          older_d[i][j] = 1'b0;
        end
      end
    end
  end

  // Matrix storage, emptied on reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  // A candidate is oldest when no other candidate is older than it.
  always_comb begin
    oldest_onehot_o = mask_i;
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        if (mask_i[j] && older_q[j][i]) begin
          oldest_onehot_o[i] = 1'b0;
        end
      end
    end
  end

  assign older_than_o = older_q;

endmodule
`default_nettype wire

// File: rtl/simmem_resp_slot_bank.sv
`default_nettype none
// ============================================================================
// Module : simmem_resp_slot_bank
// Brief  : Response storage bank. Reserves a slot per request, stores the
//          real memory response in the oldest matching reserved slot and
//          releases it downstream when the delay bank enables that slot,
//          keeping per-ID order.
// Rev    : 1.0 - initial release
// ============================================================================
module simmem_resp_slot_bank
  import simmem_pkg::*;
#(
  parameter  int unsigned Capacity     = DefaultCapacity,
  parameter  int unsigned IdWidth      = DefaultIdWidth,
  parameter  int unsigned DataWidth    = DefaultDataWidth,
  localparam int unsigned LocalIdWidth = $clog2(Capacity)
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic [IdWidth-1:0]      res_id_i,
  output logic [LocalIdWidth-1:0] res_local_id_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [IdWidth-1:0]      in_id_i,
  input  logic [DataWidth-1:0]    in_data_i,
  input  logic [Capacity-1:0]     release_en_i,
  output logic [Capacity-1:0]     released_onehot_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [IdWidth-1:0]      out_id_o,
  output logic [DataWidth-1:0]    out_data_o
);

  slot_state_e            state_q [Capacity];
  slot_state_e            state_d [Capacity];
  logic [IdWidth-1:0]     id_q    [Capacity];
  logic [DataWidth-1:0]   data_q  [Capacity];

  logic [Capacity-1:0]    free_vec, live_vec, match_vec, elig_vec;
  logic [Capacity-1:0]    res_onehot, sel_onehot, fill_onehot;
  logic [Capacity-1:0]    age_set, age_clear;
  logic [Capacity-1:0][Capacity-1:0] older;
  logic [LocalIdWidth-1:0] res_idx, sel_idx;
  logic                   res_fire, in_fire, out_fire;

  // Per-slot status vectors and release eligibility (no older live same-ID slot).
  always_comb begin
    free_vec  = '0;
    live_vec  = '0;
    match_vec = '0;
    elig_vec  = '0;
    for (int i = 0; i < Capacity; i++) begin
      free_vec[i]  = (state_q[i] == SLOT_FREE);
      live_vec[i]  = (state_q[i] != SLOT_FREE);
      match_vec[i] = (state_q[i] == SLOT_RESERVED) && (id_q[i] == in_id_i);
      elig_vec[i]  = (state_q[i] == SLOT_FILLED) && release_en_i[i];
      for (int j = 0; j < Capacity; j++) begin
        if ((state_q[j] != SLOT_FREE) && (id_q[j] == id_q[i]) && older[j][i]) begin
          elig_vec[i] = 1'b0;
        end
      end
    end
  end

  // Lowest-index free slot for reservation and lowest-index eligible slot for release.
  always_comb begin
    res_onehot = '0;
    sel_onehot = '0;
    res_idx    = '0;
    sel_idx    = '0;
    for (int i = Capacity - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        res_onehot     = '0;
        res_onehot[i]  = 1'b1;
        res_idx        = LocalIdWidth'(i);
      end
      if (elig_vec[i]) begin
        sel_onehot     = '0;
        sel_onehot[i]  = 1'b1;
        sel_idx        = LocalIdWidth'(i);
      end
    end
  end

  assign res_ready_o    = |free_vec;
  assign res_local_id_o = res_idx;
  assign in_ready_o     = |match_vec;
  assign out_valid_o    = |elig_vec;

  assign res_fire = res_valid_i && res_ready_o;
  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  assign out_id_o          = out_valid_o ? id_q[sel_idx]   : '0;
  assign out_data_o        = out_valid_o ? data_q[sel_idx] : '0;
  assign released_onehot_o = out_fire ? sel_onehot : '0;

  assign age_set   = res_fire ? res_onehot : '0;
  assign age_clear = out_fire ? sel_onehot : '0;

  simmem_age_matrix #(
    .Capacity (Capacity)
  ) u_age (
    .clk             (clk),
    .rst_ni          (rst_ni),
    .set_onehot_i    (age_set),
    .clear_onehot_i  (age_clear),
    .live_i          (live_vec),
    .mask_i          (match_vec),
    .oldest_onehot_o (fill_onehot),
    .older_than_o    (older)
  );

  // Slot transitions; reserve, fill and release always touch distinct slots.
  always_comb begin
    for (int i = 0; i < Capacity; i++) begin
      state_d[i] = state_q[i];
      if (res_fire && res_onehot[i]) begin
        state_d[i] = SLOT_RESERVED;
      end
      if (in_fire && fill_onehot[i]) begin
        state_d[i] = SLOT_FILLED;
      end
      if (out_fire && sel_onehot[i]) begin
        state_d[i] = SLOT_FREE;
      end
    end
  end

  // Slot state, ID and payload storage.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i] <= SLOT_FREE;
        id_q[i]    <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i] <= state_d[i];
        if (res_fire && res_onehot[i]) begin
          id_q[i] <= res_id_i;
        end
        if (in_fire && fill_onehot[i]) begin
          data_q[i] <= in_data_i;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simmem_resp_slot_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_simmem_resp_slot_bank
// Brief  : Self-checking bench for simmem_resp_slot_bank at Capacity=4.
//          Expected releases are queued when a fill is driven and popped
//          when the bank hands a response out.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_simmem_resp_slot_bank;
  import simmem_pkg::*;

  localparam int unsigned Cap = 4;
  localparam int unsigned IdW = 4;
  localparam int unsigned DW  = 16;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           res_valid_i;
  logic           res_ready_o;
  logic [IdW-1:0] res_id_i;
  logic [1:0]     res_local_id_o;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [IdW-1:0] in_id_i;
  logic [DW-1:0]  in_data_i;
  logic [Cap-1:0] release_en_i;
  logic [Cap-1:0] released_onehot_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [IdW-1:0] out_id_o;
  logic [DW-1:0]  out_data_o;

  int n_cmp = 0;
  int n_err = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  simmem_resp_slot_bank #(
    .Capacity  (Cap),
    .IdWidth   (IdW),
    .DataWidth (DW)
  ) dut (
    .clk               (clk),
    .rst_ni            (rst_ni),
    .res_valid_i       (res_valid_i),
    .res_ready_o       (res_ready_o),
    .res_id_i          (res_id_i),
    .res_local_id_o    (res_local_id_o),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_id_i           (in_id_i),
    .in_data_i         (in_data_i),
    .release_en_i      (release_en_i),
    .released_onehot_o (released_onehot_o),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_id_o          (out_id_o),
    .out_data_o        (out_data_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res_valid_i  = 1'b0;
    res_id_i     = '0;
    in_valid_i   = 1'b0;
    in_id_i      = '0;
    in_data_i    = '0;
    release_en_i = '0;
    out_ready_i  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    n_cmp++;
    if (res_ready_o !== 1'b1 || res_local_id_o !== 2'd0 || in_ready_o !== 1'b0 ||
        out_valid_o !== 1'b0 || released_onehot_o !== 4'b0 ||
        out_id_o !== 4'h0 || out_data_o !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rr=%b lid=%0d ir=%b ov=%b rel=%b id=%h d=%h, want 1 0 0 0 0000 0 0",
               res_ready_o, res_local_id_o, in_ready_o, out_valid_o, released_onehot_o, out_id_o, out_data_o);
    end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reserve();
    logic [IdW-1:0] ids [4] = '{4'd1, 4'd2, 4'd1, 4'd3};
    for (int i = 0; i < 4; i++) begin
      res_valid_i = 1'b1;
      res_id_i    = ids[i];
      @(negedge clk);
      n_cmp++;
      if (res_ready_o !== 1'b1 || res_local_id_o !== 2'(i)) begin
        n_err++;
        $display("FAIL reserve_grant%0d: got ready=%b id=%0d, want ready=1 id=%0d",
                 i, res_ready_o, res_local_id_o, i);
      end
      tick();
    end
    res_valid_i = 1'b1;
    res_id_i    = 4'd7;
    @(negedge clk);
    n_cmp++;
    if (res_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reserve_full: got ready=%b, want 0", res_ready_o);
    end
    tick();
    res_valid_i = 1'b0;
    in_id_i     = 4'd7;
    @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reserve_fifth_rejected: got in_ready=%b for id 7, want 0", in_ready_o);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [DW-1:0] datas [2] = '{16'hAAAA, 16'hBBBB};
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      in_id_i    = 4'd1;
      in_data_i  = datas[i];
      @(negedge clk);
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL fill_ready%0d: got in_ready=%b, want 1", i, in_ready_o);
      end
      exp_q.push_back('{id: 4'd1, data: datas[i]});
      tick();
    end
    in_valid_i = 1'b0;
    in_id_i    = 4'd1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL fill_id1_exhausted: got in_ready=%b, want 0", in_ready_o);
    end
    in_id_i = 4'd5;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL fill_unmatched: got in_ready=%b, want 0", in_ready_o);
    end
    tick();
  endtask

  task automatic test_order();
    resp_t e;
    logic [Cap-1:0] exp_rel [2] = '{4'b0001, 4'b0100};
    release_en_i = 4'b0100;
    out_ready_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL order_blocked: got out_valid=%b, want 0", out_valid_o);
    end
    tick();
    release_en_i = 4'b0101;
    out_ready_i  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL order_pop%0d: got empty scoreboard, want entry", i);
      end else begin
        e = exp_q.pop_front();
        if (out_valid_o !== 1'b1 || out_id_o !== e.id || out_data_o !== e.data ||
            released_onehot_o !== exp_rel[i]) begin
          n_err++;
          $display("FAIL order_release%0d: got v=%b id=%h d=%h rel=%b, want v=1 id=%h d=%h rel=%b",
                   i, out_valid_o, out_id_o, out_data_o, released_onehot_o, e.id, e.data, exp_rel[i]);
        end
      end
      tick();
    end
    release_en_i = '0;
    out_ready_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid_o !== 1'b0 || out_id_o !== 4'h0 || out_data_o !== 16'h0) begin
      n_err++;
      $display("FAIL order_idle: got v=%b id=%h d=%h, want 0 0 0", out_valid_o, out_id_o, out_data_o);
    end
    tick();
  endtask

  task automatic test_stall();
    resp_t e;
    // slot 1 holds ID 2
    in_valid_i = 1'b1;
    in_id_i    = 4'd2;
    in_data_i  = 16'h1234;
    exp_q.push_back('{id: 4'd2, data: 16'h1234});
    tick();
    in_valid_i   = 1'b0;
    release_en_i = 4'b0010;
    out_ready_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid_o !== 1'b1 || out_data_o !== 16'h1234 || released_onehot_o !== 4'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b d=%h rel=%b, want 1 1234 0000",
                 c, out_valid_o, out_data_o, released_onehot_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '{id: 4'hF, data: 16'hDEAD};
    if (released_onehot_o !== 4'b0010 || out_id_o !== e.id || out_data_o !== e.data) begin
      n_err++;
      $display("FAIL stall_accept: got rel=%b id=%h d=%h, want 0010 %h %h",
               released_onehot_o, out_id_o, out_data_o, e.id, e.data);
    end
    tick();
    out_ready_i  = 1'b0;
    release_en_i = '0;
    res_valid_i  = 1'b1;
    res_id_i     = 4'd4;
    @(negedge clk);
    n_cmp++;
    if (released_onehot_o !== 4'b0 || res_local_id_o !== 2'd0) begin
      n_err++;
      $display("FAIL stall_after: got rel=%b lid=%0d, want 0000 0", released_onehot_o, res_local_id_o);
    end
    tick();
    res_id_i = 4'd5;
    @(negedge clk);
    n_cmp++;
    if (res_ready_o !== 1'b1 || res_local_id_o !== 2'd1) begin
      n_err++;
      $display("FAIL stall_slot_freed: got ready=%b lid=%0d, want 1 1", res_ready_o, res_local_id_o);
    end
    tick();
    res_id_i = 4'd6;
    tick();
    res_valid_i = 1'b0;
  endtask

  task automatic test_full_release();
    resp_t e;
    // slots: 0=ID4 1=ID5 2=ID6 3=ID3, all reserved
    in_valid_i = 1'b1;
    in_id_i    = 4'd5;
    in_data_i  = 16'h5555;
    exp_q.push_back('{id: 4'd5, data: 16'h5555});
    tick();
    in_valid_i   = 1'b0;
    release_en_i = 4'b0010;
    out_ready_i  = 1'b1;
    res_valid_i  = 1'b1;
    res_id_i     = 4'd9;
    @(negedge clk);
    n_cmp++;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '{id: 4'hF, data: 16'hDEAD};
    if (res_ready_o !== 1'b0 || released_onehot_o !== 4'b0010 || out_data_o !== e.data) begin
      n_err++;
      $display("FAIL full_release_same_cycle: got rr=%b rel=%b d=%h, want 0 0010 %h",
               res_ready_o, released_onehot_o, out_data_o, e.data);
    end
    tick();
    release_en_i = '0;
    out_ready_i  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_ready_o !== 1'b1 || res_local_id_o !== 2'd1) begin
      n_err++;
      $display("FAIL full_regrant: got rr=%b lid=%0d, want 1 1", res_ready_o, res_local_id_o);
    end
    tick();
    res_valid_i = 1'b0;
    in_id_i     = 4'd9;
    @(negedge clk);
    n_cmp++;
    if (res_ready_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL full_regrant_stored: got rr=%b ir=%b, want 0 1", res_ready_o, in_ready_o);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [IdW-1:0] ids [3] = '{4'd4, 4'd6, 4'd3};
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_id_i    = ids[i];
      in_data_i  = 16'(i + 1);
      tick();
    end
    in_valid_i   = 1'b0;
    release_en_i = 4'b1111;
    @(negedge clk);
    n_cmp++;
    if (out_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: got out_valid=%b, want 1", out_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0 || res_ready_o !== 1'b1 || res_local_id_o !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_async: got ov=%b rr=%b lid=%0d, want 0 1 0",
               out_valid_o, res_ready_o, res_local_id_o);
    end
    exp_q.delete();
    idle_inputs();
    tick();
    tick();
    rst_ni      = 1'b1;
    res_valid_i = 1'b1;
    res_id_i    = 4'd8;
    @(negedge clk);
    n_cmp++;
    if (res_ready_o !== 1'b1 || res_local_id_o !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_first_grant: got rr=%b lid=%0d, want 1 0", res_ready_o, res_local_id_o);
    end
    tick();
    res_valid_i = 1'b0;
    in_id_i     = 4'd8;
    @(negedge clk);
    n_cmp++;
    if (in_ready_o !== 1'b1 || res_local_id_o !== 2'd1) begin
      n_err++;
      $display("FAIL midreset_after_grant: got ir=%b lid=%0d, want 1 1", in_ready_o, res_local_id_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_reserve();
    test_fill();
    test_order();
    test_stall();
    test_full_release();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
